instr_reorder_ctrl: RTL

- Sequencer for the instruction reorder buffer.
- Drives the buffer's slot index: linear fill first, then a programmable permutation read from a mapping table, then drains the remaining entries.
- Tracks slot occupancy, flags which buffer outputs are real instructions, and signals completion.
- Sits between the instruction fetch stream and the reorder buffer; the map is loaded by the config path.

---
 rtl/instr_reorder_pkg.sv | 19 +
 rtl/reorder_map_table.sv | 36 +++
 rtl/instr_reorder_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/instr_reorder_pkg.sv
// Shared definitions for the instruction reorder sequencer.
// Provides the controller state encoding, the default buffer depth and
// the slot-index width helper used by the controller and its map table.
package instr_reorder_pkg;

  localparam int BS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    MAP  = 2'd2
  } state_t;

  // Width of a slot index for a buffer of the given depth (min 1 bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reorder_map_table.sv
// Programmable slot-permutation table for the reorder sequencer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (restores identity map)
//   we        - write enable (qualified by the controller)
//   waddr     - write address (table entry)
//   wdata     - write data (slot index)
//   raddr     - combinational read address
//   rdata     - combinational read data
module reorder_map_table
  import instr_reorder_pkg::*;
#(
  parameter int BS   = BS_DEFAULT,
  parameter int IDXW = idx_w(BS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  logic [IDXW-1:0] wdata,
  input  logic [IDXW-1:0] raddr,
  output logic [IDXW-1:0] rdata
);

  logic [BS-1:0][IDXW-1:0] tbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) tbl[i] <= IDXW'(i);
    end else if (we) begin
      tbl[waddr] <= wdata;
    end
  end

  assign rdata = tbl[raddr];

endmodule

// File: rtl/instr_reorder_ctrl.sv
// Sequencer for the instruction reorder buffer.
// Fills the buffer linearly, then issues slot indices from the mapping
// table, draining until every occupied slot has been read (or a drain
// timeout flags a non-permutation map).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - start pulse, honoured only in IDLE
//   instr_nz   - current instruction is non-zero (zero = end of stream)
//   buf_start  - buffer full or input exhausted
//   buf_index  - registered slot index to the buffer
//   out_valid  - buffer output this cycle is a real instruction
//   map_we/map_addr/map_data - mapping table write port (IDLE only)
//   busy       - run in progress
//   done       - one-cycle end-of-run pulse
//   map_err    - sticky drain-timeout flag, cleared by the next en
module instr_reorder_ctrl
  import instr_reorder_pkg::*;
#(
  parameter int BS   = BS_DEFAULT,
  parameter int IW   = 32,
  parameter int IDXW = idx_w(BS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            instr_nz,
  input  logic            buf_start,
  output logic [IDXW-1:0] buf_index,
  output logic            out_valid,
  input  logic            map_we,
  input  logic [IDXW-1:0] map_addr,
  input  logic [IDXW-1:0] map_data,
  output logic            busy,
  output logic            done,
  output logic            map_err
);

  if ((BS < 2) || ((BS & (BS - 1)) != 0) || (IW < 1)) begin : g_param_chk
    $error("instr_reorder_ctrl: BS must be a power of two >= 2 and IW >= 1");
  end

  state_t          state;
  logic [BS-1:0]   occ, occ_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW:0]   drain_cnt, drain_nxt;
  logic            end_seen, ended;
  logic            map_wr;
  logic [IDXW-1:0] map_raddr, map_rdata;

  // Table is only writable between runs.
  assign map_wr  = map_we && (state == IDLE);
  assign ptr_nxt = ptr + 1'b1;
  // ptr tracks the entry currently presented; look one entry ahead so the
  // registered buf_index steps map[0], map[1], ... without repeats.
  assign map_raddr = (state == MAP) ? ptr_nxt : '0;

  reorder_map_table #(.BS(BS), .IDXW(IDXW)) u_map (
    .clk   (clk),
    .rst   (rst),
    .we    (map_wr),
    .waddr (map_addr),
    .wdata (map_data),
    .raddr (map_raddr),
    .rdata (map_rdata)
  );

  // Occupancy after this cycle's buffer write into the presented slot.
  always_comb begin
    occ_nxt            = occ;
    occ_nxt[buf_index] = instr_nz;
  end

  // The cycle that first sees the zero instruction already counts as drain.
  assign ended     = end_seen | ~instr_nz;
  assign drain_nxt = drain_cnt + {{IDXW{1'b0}}, ended};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      map_err   <= 1'b0;
      occ       <= '0;
      ptr       <= '0;
      drain_cnt <= '0;
      end_seen  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          buf_index <= '0;
          out_valid <= 1'b0;
          if (en) begin
            state     <= FILL;
            busy      <= 1'b1;
            map_err   <= 1'b0;
            occ       <= '0;
            ptr       <= '0;
            drain_cnt <= '0;
            end_seen  <= 1'b0;
          end
        end
        FILL: begin
          occ       <= occ_nxt;
          out_valid <= occ[buf_index];
          if (buf_start) begin
            state     <= MAP;
            ptr       <= '0;
            buf_index <= map_rdata;
          end else begin
            buf_index <= buf_index + 1'b1;
          end
        end
        MAP: begin
          occ       <= occ_nxt;
          out_valid <= occ[buf_index];
          buf_index <= map_rdata;
          ptr       <= ptr_nxt;
          if (!instr_nz) end_seen  <= 1'b1;
          if (ended)     drain_cnt <= drain_nxt;
          if (ended && (occ_nxt == '0)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            buf_index <= '0;
          end else if (drain_nxt == (IDXW+1)'(BS)) begin
            // Map is not a permutation: some slots are never revisited.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            map_err   <= 1'b1;
            buf_index <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
